// File: rtl/flashrom_boot_sequencer.sv
// rtl/flashrom_boot_sequencer.sv - boot-time FlashROM to instruction-memory copy engine
// Optional running checksum enabled by defining FLASHROM_BOOT_CHECKSUM_EN.
module flashrom_boot_sequencer #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int BOOT_LENGTH = 1024
) (
    input  logic                  clk,
    input  logic                  sync_rst,
    input  logic                  BootRequest,
    output logic [ADDR_WIDTH-1:0] RomAddress,
    input  logic [DATA_WIDTH-1:0] RomValue,
    output logic                  MemWriteValid,
    output logic [ADDR_WIDTH-1:0] MemWriteAddress,
    output logic [DATA_WIDTH-1:0] MemWriteData,
    input  logic                  MemWriteReady,
    output logic                  CoreHold,
    output logic                  BootDone,
    output logic [DATA_WIDTH-1:0] BootChecksum
);

    // Pointer carries one extra bit so a full-size image never wraps.
    localparam logic [ADDR_WIDTH:0] LAST_PTR = (ADDR_WIDTH+1)'(BOOT_LENGTH - 1);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH:0]   ptr;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  hold_q;
    logic                  done_q;

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state   <= FETCH;
            ptr     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    data_q  <= RomValue;
                    valid_q <= 1'b1;
                    state   <= WRITE;
                end
                WRITE: begin
                    if (MemWriteReady) begin
                        valid_q <= 1'b0;
                        if (ptr == LAST_PTR) begin
                            state  <= DONE;
                            hold_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            ptr   <= ptr + 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    if (BootRequest) begin
                        ptr    <= '0;
                        hold_q <= 1'b1;
                        done_q <= 1'b0;
                        state  <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    // ROM bus is parked at zero once the image is loaded.
    assign RomAddress      = (state == DONE) ? '0 : ptr[ADDR_WIDTH-1:0];
    assign MemWriteValid   = valid_q;
    assign MemWriteAddress = ptr[ADDR_WIDTH-1:0];
    assign MemWriteData    = data_q;
    assign CoreHold        = hold_q;
    assign BootDone        = done_q;

`ifdef FLASHROM_BOOT_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q;

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            csum_q <= '0;
        end else if (state == WRITE && MemWriteReady) begin
            csum_q <= csum_q + data_q;
        end else if (state == DONE && BootRequest) begin
            csum_q <= '0;
        end
    end

    assign BootChecksum = csum_q;
`else
    assign BootChecksum = '0;
`endif

endmodule

// File: tb/tb_flashrom_boot_sequencer.sv
// tb/tb_flashrom_boot_sequencer.sv - self-checking bench for flashrom_boot_sequencer
// Honours FLASHROM_BOOT_CHECKSUM_EN when computing expected checksums.
module tb_flashrom_boot_sequencer;

`ifdef FLASHROM_BOOT_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    localparam int LEN_A = 4;
    localparam int LEN_B = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, breq_a, ready_a, valid_a, hold_a, done_a;
    logic [9:0]  rom_addr_a, wr_addr_a;
    logic [15:0] rom_val_a, wr_data_a, csum_a;
    logic [15:0] rom_a [0:1023];

    logic        rst_b, breq_b, ready_b, valid_b, hold_b, done_b;
    logic [9:0]  rom_addr_b, wr_addr_b;
    logic [15:0] rom_val_b, wr_data_b, csum_b;

    int checks = 0;
    int errors = 0;
    int stall [0:LEN_A-1];

    assign rom_val_a = rom_a[rom_addr_a];
    assign rom_val_b = {6'b0, rom_addr_b};

    flashrom_boot_sequencer #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .BOOT_LENGTH(LEN_A)) dut_a (
        .clk(clk), .sync_rst(rst_a), .BootRequest(breq_a),
        .RomAddress(rom_addr_a), .RomValue(rom_val_a),
        .MemWriteValid(valid_a), .MemWriteAddress(wr_addr_a), .MemWriteData(wr_data_a),
        .MemWriteReady(ready_a), .CoreHold(hold_a), .BootDone(done_a), .BootChecksum(csum_a)
    );

    flashrom_boot_sequencer #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .BOOT_LENGTH(LEN_B)) dut_b (
        .clk(clk), .sync_rst(rst_b), .BootRequest(breq_b),
        .RomAddress(rom_addr_b), .RomValue(rom_val_b),
        .MemWriteValid(valid_b), .MemWriteAddress(wr_addr_b), .MemWriteData(wr_data_b),
        .MemWriteReady(ready_b), .CoreHold(hold_b), .BootDone(done_b), .BootChecksum(csum_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] csum_exp(input logic [15:0] sum);
        return CSUM_EN ? sum : 16'h0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_a(input string tag, input logic v, input logic [9:0] wa,
                            input logic [15:0] wd, input logic [9:0] ra, input logic hold,
                            input logic done, input logic [15:0] cs, input bit chk_wr);
        check({tag, ".valid"}, 64'(valid_a), 64'(v));
        if (v || chk_wr) begin
            check({tag, ".waddr"}, 64'(wr_addr_a), 64'(wa));
            check({tag, ".wdata"}, 64'(wr_data_a), 64'(wd));
        end
        check({tag, ".romaddr"}, 64'(rom_addr_a), 64'(ra));
        check({tag, ".hold"}, 64'(hold_a), 64'(hold));
        check({tag, ".done"}, 64'(done_a), 64'(done));
        check({tag, ".csum"}, 64'(csum_a), 64'(cs));
    endtask

    // Timeline model: word k spends one FETCH cycle then stall[k]+1 WRITE cycles.
    task automatic run_copy(input int breq_cycle, input int rst_cycle, input int done_cycles);
        int c;
        logic [15:0] sum;
        c = 0;
        sum = 16'h0;
        for (int k = 0; k < LEN_A; k++) begin
            expect_a("fetch", 1'b0, 10'h0, 16'h0, 10'(k), 1'b1, 1'b0, csum_exp(sum), 1'b0);
            ready_a = 1'($urandom);
            breq_a  = (c == breq_cycle);
            step();
            c++;
            for (int s = 0; s <= stall[k]; s++) begin
                expect_a("write", 1'b1, 10'(k), rom_a[k], 10'(k), 1'b1, 1'b0, csum_exp(sum), 1'b1);
                if (c == rst_cycle) begin
                    rst_a   = 1'b1;
                    ready_a = 1'b0;
                    breq_a  = 1'b1;
                    step();
                    breq_a  = 1'b0;
                    expect_a("reset", 1'b0, 10'h0, 16'h0, 10'h0, 1'b1, 1'b0, 16'h0, 1'b1);
                    return;
                end
                ready_a = (s == stall[k]);
                breq_a  = (c == breq_cycle);
                step();
                c++;
            end
            sum = sum + rom_a[k];
        end
        for (int d = 0; d < done_cycles; d++) begin
            expect_a("done", 1'b0, 10'h0, 16'h0, 10'h0, 1'b0, 1'b1, csum_exp(sum), 1'b0);
            ready_a = 1'($urandom);
            breq_a  = 1'b0;
            step();
        end
    endtask

    task automatic boot_req();
        check("bootreq.done", 64'(done_a), 64'(1));
        breq_a  = 1'b1;
        ready_a = 1'($urandom);
        step();
        breq_a  = 1'b0;
    endtask

    task automatic clear_stalls();
        for (int k = 0; k < LEN_A; k++) stall[k] = 0;
    endtask

    initial begin
        logic [15:0] sum_b;
        rst_a = 1'b1; breq_a = 1'b0; ready_a = 1'b0;
        rst_b = 1'b1; breq_b = 1'b0; ready_b = 1'b1;
        for (int i = 0; i < 1024; i++) rom_a[i] = 16'($urandom);
        rom_a[0] = 16'hD188; rom_a[1] = 16'hC220; rom_a[2] = 16'hE200; rom_a[3] = 16'hC300;
        clear_stalls();
        step();
        step();
        expect_a("reset_hold", 1'b0, 10'h0, 16'h0, 10'h0, 1'b1, 1'b0, 16'h0, 1'b1);
        rst_a = 1'b0;

        run_copy(-1, -1, 2);
        boot_req();
        run_copy(-1, -1, 2);

        stall[2] = 3;
        boot_req();
        run_copy(-1, -1, 2);

        clear_stalls();
        boot_req();
        run_copy(2, -1, 2);

        stall[2] = 1;
        boot_req();
        run_copy(-1, 5, 0);
        rst_a = 1'b0;
        clear_stalls();
        run_copy(-1, -1, 2);

        for (int it = 0; it < 20; it++) begin
            for (int k = 0; k < LEN_A; k++) begin
                rom_a[k] = 16'($urandom);
                stall[k] = int'($urandom_range(0, 3));
            end
            boot_req();
            run_copy(int'($urandom_range(0, 7)), -1, 1 + int'($urandom_range(0, 2)));
        end

        rst_b = 1'b0;
        sum_b = 16'h0;
        for (int c = 0; c < 2 * LEN_B; c++) begin
            check("big.valid", 64'(valid_b), 64'(c % 2));
            check("big.hold", 64'(hold_b), 64'(1));
            if (c % 2 == 1) begin
                check("big.waddr", 64'(wr_addr_b), 64'((c - 1) / 2));
                check("big.wdata", 64'(wr_data_b), 64'((c - 1) / 2));
                sum_b = sum_b + 16'((c - 1) / 2);
            end else begin
                check("big.romaddr", 64'(rom_addr_b), 64'(c / 2));
            end
            step();
        end
        check("big.done", 64'(done_b), 64'(1));
        check("big.hold_end", 64'(hold_b), 64'(0));
        check("big.valid_end", 64'(valid_b), 64'(0));
        check("big.csum", 64'(csum_b), 64'(csum_exp(sum_b)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
